// File: rtl/frame_strobe_ctrl.sv
// Frame write controller: presents one data word to a tile column and pulses
// the addressed frame strobe with programmable setup, strobe and hold phases.
module frame_strobe_ctrl #(
   parameter int MaxFramesPerCol = 20,
   parameter int FrameBitsPerRow = 32,
   parameter int SetupCycles     = 2,
   parameter int StrobeCycles    = 1,
   parameter int HoldCycles      = 1
) (
   input  logic                       UserCLK,
   input  logic                       Reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [4:0]                 req_frame,
   input  logic [FrameBitsPerRow-1:0] req_data,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [1:0]                 state_dbg
);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE and never in reset.

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                     state;
   logic [7:0]                 cnt;
   logic [4:0]                 frame_q;
   logic                       accept;
   logic                       frame_ok;
   logic [MaxFramesPerCol-1:0] strobe_vec;

   assign req_ready = (state == IDLE) && !Reset;
   assign accept    = req_valid && req_ready;
   assign frame_ok  = 32'(req_frame) < 32'(MaxFramesPerCol);
   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_comb begin
      strobe_vec = '0;
      for (int i = 0; i < MaxFramesPerCol; i++) begin
         strobe_vec[i] = (32'(frame_q) == 32'(i));
      end
   end

   // Each phase loads cnt with its length minus one and leaves when it hits 0.
   always_ff @(posedge UserCLK or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         cnt         <= 8'd0;
         frame_q     <= 5'd0;
         FrameData   <= '0;
         FrameStrobe <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (frame_ok) begin
                     FrameData <= req_data;
                     frame_q   <= req_frame;
                     cnt       <= 8'(SetupCycles - 1);
                     state     <= SETUP;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SETUP: begin
               if (cnt == 8'd0) begin
                  FrameStrobe <= strobe_vec;
                  cnt         <= 8'(StrobeCycles - 1);
                  state       <= STROBE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            STROBE: begin
               if (cnt == 8'd0) begin
                  FrameStrobe <= '0;
                  cnt         <= 8'(HoldCycles - 1);
                  state       <= HOLD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HOLD: begin
               if (cnt == 8'd0) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               FrameStrobe <= '0;
               cnt         <= 8'd0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_strobe_ctrl.sv
// Directed bench for frame_strobe_ctrl: default timing instance plus an
// instance with stretched strobe/hold phases.
module tb_frame_strobe_ctrl;

   logic        UserCLK = 1'b0;
   logic        Reset;
   logic        req_valid, req_ready;
   logic [4:0]  req_frame;
   logic [31:0] req_data, FrameData;
   logic [19:0] FrameStrobe;
   logic        busy, done, err;
   logic [1:0]  state_dbg;

   logic        req_valid_b, req_ready_b;
   logic [4:0]  req_frame_b;
   logic [31:0] req_data_b, FrameData_b;
   logic [19:0] FrameStrobe_b;
   logic        busy_b, done_b, err_b;
   logic [1:0]  state_dbg_b;

   int errors = 0;
   int checks = 0;

   always #5 UserCLK = ~UserCLK;

   frame_strobe_ctrl u_dut (
      .UserCLK(UserCLK), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_frame(req_frame), .req_data(req_data), .FrameData(FrameData),
      .FrameStrobe(FrameStrobe), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
   );

   frame_strobe_ctrl #(.SetupCycles(1), .StrobeCycles(3), .HoldCycles(2)) u_dut_b (
      .UserCLK(UserCLK), .Reset(Reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_frame(req_frame_b), .req_data(req_data_b), .FrameData(FrameData_b),
      .FrameStrobe(FrameStrobe_b), .busy(busy_b), .done(done_b), .err(err_b),
      .state_dbg(state_dbg_b)
   );

   // FrameStrobe must be one-hot or zero on every cycle, and done/err exclusive.
   always @(negedge UserCLK) begin
      checks++;
      if (!$onehot0(FrameStrobe) || !$onehot0(FrameStrobe_b) || (done && err)) begin
         errors++;
         $display("FAIL monitor_onehot got=%h/%h done=%b err=%b required onehot0 and !(done&err)",
                  FrameStrobe, FrameStrobe_b, done, err);
      end
   end

   task automatic drive_req(input logic [4:0] f, input logic [31:0] d);
      req_valid = 1'b1;
      req_frame = f;
      req_data  = d;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      drive_req(5'd2, 32'h5555_5555);
      req_valid_b = 1'b0; req_frame_b = 5'd0; req_data_b = 32'h0;
      @(negedge UserCLK);
      checks++;
      if ({req_ready, busy, done, err, state_dbg} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b required=000000", {req_ready, busy, done, err, state_dbg});
      end
      checks++;
      if (FrameData !== 32'h0 || FrameStrobe !== 20'h0) begin
         errors++;
         $display("FAIL reset_data got=%h/%h required=0/0", FrameData, FrameStrobe);
      end
      @(negedge UserCLK);
      Reset = 1'b0;
      req_valid = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b required=1", req_ready);
      end
      @(negedge UserCLK);
      checks++;
      if (busy !== 1'b0 || FrameData !== 32'h0) begin
         errors++;
         $display("FAIL reset_no_accept got busy=%b data=%h required busy=0 data=0", busy, FrameData);
      end
   endtask

   task automatic test_basic();
      drive_req(5'd3, 32'hDEAD_BEEF);
      for (int k = 1; k <= 5; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid = 1'b0;
         checks++;
         if (FrameData !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL basic_data k=%0d got=%h required=deadbeef", k, FrameData);
         end
         checks++;
         if (FrameStrobe !== ((k == 3) ? 20'h00008 : 20'h0)) begin
            errors++;
            $display("FAIL basic_strobe k=%0d got=%h", k, FrameStrobe);
         end
         checks++;
         if (done !== (k == 5) || busy !== (k <= 4) || req_ready !== (k == 5)) begin
            errors++;
            $display("FAIL basic_ctrl k=%0d got done=%b busy=%b ready=%b", k, done, busy, req_ready);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive_req(5'd19, 32'hA5A5_0001);
      for (int k = 1; k <= 5; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid = 1'b0;
         checks++;
         if (FrameStrobe !== ((k == 3) ? 20'h80000 : 20'h0)) begin
            errors++;
            $display("FAIL b2b_strobe1 k=%0d got=%h", k, FrameStrobe);
         end
      end
      checks++;
      if (done !== 1'b1 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done1 got done=%b ready=%b required 1/1", done, req_ready);
      end
      drive_req(5'd0, 32'h0BAD_F00D);
      for (int j = 1; j <= 5; j++) begin
         @(negedge UserCLK);
         if (j == 1) req_valid = 1'b0;
         checks++;
         if (FrameData !== 32'h0BAD_F00D || FrameStrobe !== ((j == 3) ? 20'h00001 : 20'h0)) begin
            errors++;
            $display("FAIL b2b_second j=%0d got data=%h strobe=%h", j, FrameData, FrameStrobe);
         end
         checks++;
         if (done !== (j == 5) || busy !== (j <= 4)) begin
            errors++;
            $display("FAIL b2b_ctrl2 j=%0d got done=%b busy=%b", j, done, busy);
         end
      end
   endtask

   task automatic test_bad_frame();
      drive_req(5'd20, 32'h1234_5678);
      for (int k = 1; k <= 5; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid = 1'b0;
         checks++;
         if (err !== (k == 1) || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_ctrl k=%0d got err=%b done=%b busy=%b ready=%b",
                     k, err, done, busy, req_ready);
         end
         checks++;
         if (FrameData !== 32'h0BAD_F00D || FrameStrobe !== 20'h0) begin
            errors++;
            $display("FAIL bad_data k=%0d got data=%h strobe=%h required 0badf00d/0",
                     k, FrameData, FrameStrobe);
         end
      end
   endtask

   task automatic test_ignore_busy();
      drive_req(5'd5, 32'hC0DE_0005);
      for (int k = 1; k <= 6; k++) begin
         @(negedge UserCLK);
         if (k <= 3) begin
            req_valid = k[0];
            req_frame = 5'(k + 8);
            req_data  = 32'hFFFF_0000 | 32'(k);
         end else begin
            req_valid = 1'b0;
         end
         checks++;
         if (FrameData !== 32'hC0DE_0005 || FrameStrobe !== ((k == 3) ? 20'h00020 : 20'h0)) begin
            errors++;
            $display("FAIL busy_ignore k=%0d got data=%h strobe=%h", k, FrameData, FrameStrobe);
         end
         checks++;
         if (done !== (k == 5) || busy !== (k <= 4)) begin
            errors++;
            $display("FAIL busy_ctrl k=%0d got done=%b busy=%b", k, done, busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive_req(5'd7, 32'h7777_0007);
      for (int k = 1; k <= 3; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid = 1'b0;
      end
      checks++;
      if (FrameStrobe !== 20'h00080) begin
         errors++;
         $display("FAIL mid_strobe got=%h required=00080", FrameStrobe);
      end
      Reset = 1'b1;
      #1;
      checks++;
      if (FrameStrobe !== 20'h0 || FrameData !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_async got strobe=%h data=%h busy=%b ready=%b",
                  FrameStrobe, FrameData, busy, req_ready);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge UserCLK);
         checks++;
         if (done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold k=%0d got done=%b ready=%b required 0/0", k, done, req_ready);
         end
      end
      Reset = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_release got ready=%b done=%b required 1/0", req_ready, done);
      end
      drive_req(5'd1, 32'hE1E1_0001);
      for (int k = 1; k <= 5; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid = 1'b0;
         checks++;
         if (FrameData !== 32'hE1E1_0001 || FrameStrobe !== ((k == 3) ? 20'h00002 : 20'h0)
             || done !== (k == 5)) begin
            errors++;
            $display("FAIL mid_after k=%0d got data=%h strobe=%h done=%b",
                     k, FrameData, FrameStrobe, done);
         end
      end
   endtask

   task automatic test_timing_params();
      req_valid_b = 1'b1;
      req_frame_b = 5'd4;
      req_data_b  = 32'hF00D_0004;
      for (int k = 1; k <= 8; k++) begin
         @(negedge UserCLK);
         if (k == 1) req_valid_b = 1'b0;
         checks++;
         if (FrameStrobe_b !== ((k >= 2 && k <= 4) ? 20'h00010 : 20'h0)) begin
            errors++;
            $display("FAIL param_strobe k=%0d got=%h", k, FrameStrobe_b);
         end
         checks++;
         if (done_b !== (k == 7) || busy_b !== (k <= 6) || FrameData_b !== 32'hF00D_0004) begin
            errors++;
            $display("FAIL param_ctrl k=%0d got done=%b busy=%b data=%h",
                     k, done_b, busy_b, FrameData_b);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_frame();
      test_ignore_busy();
      test_reset_mid();
      test_timing_params();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frame_strobe_ctrl.md
FRAME_STROBE_CTRL -- requirements
Module: frame_strobe_ctrl

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobe lines in the column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: width of frame data word.
REQ-003 SHALL have parameter SetupCycles, default 2: cycles FrameData is stable before strobe; legal 1..255.
REQ-004 SHALL have parameter StrobeCycles, default 1: strobe pulse width in cycles; legal 1..255.
REQ-005 SHALL have parameter HoldCycles, default 1: cycles FrameData is held after strobe; legal 1..255.
REQ-006 SHALL have port UserCLK  input  1  the single clock; all state on rising edge.
REQ-007 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid  input  1  frame write request valid.
REQ-009 SHALL have port req_ready  output  1  controller can accept a request.
REQ-010 SHALL have port req_frame  input  5  target frame index.
REQ-011 SHALL have port req_data  input  FrameBitsPerRow  frame data word.
REQ-012 SHALL have port FrameData  output  FrameBitsPerRow  registered frame data to the tile column.
REQ-013 SHALL have port FrameStrobe  output  MaxFramesPerCol  registered one-hot (or zero) strobe vector.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on write completion.
REQ-016 SHALL have port err  output  1  one-cycle pulse on rejected request.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, with an 8-bit down-counter for phase length.
REQ-018 SHALL drive req_ready = 1 only in IDLE (not during reset); a request is accepted on a rising edge where req_valid & req_ready.
REQ-019 On acceptance with req_frame < MaxFramesPerCol: SHALL latch req_data into FrameData and the frame index internally, enter SETUP for SetupCycles cycles.
REQ-020 On acceptance with req_frame >= MaxFramesPerCol: SHALL stay IDLE, leave FrameData and FrameStrobe unchanged, and pulse err for exactly the next cycle.
REQ-021 SETUP -> STROBE after SetupCycles cycles; FrameStrobe = 1<<frame during exactly StrobeCycles cycles, all other bits 0.
REQ-022 STROBE -> HOLD; FrameStrobe = 0 throughout HOLD for HoldCycles cycles; FrameData unchanged.
REQ-023 HOLD -> IDLE; done SHALL be 1 in the first IDLE cycle only, coincident with req_ready = 1.
REQ-024 Latency accept-edge to done-high cycle SHALL be SetupCycles+StrobeCycles+HoldCycles+1 cycles (5 with defaults).
REQ-025 FrameData SHALL change only on an accepted valid request; it retains its value in IDLE after done.
REQ-026 FrameStrobe SHALL never have more than one bit set and SHALL be 0 outside STROBE.
REQ-027 req_valid and req_data/req_frame changes while req_ready = 0 SHALL be ignored; no request queuing.
REQ-028 A request presented in the done cycle SHALL be accepted (back-to-back operation, no idle gap required).
REQ-029 done and err SHALL never be high in the same cycle.

Reset
REQ-030 Reset = 1 SHALL immediately (asynchronously) force state IDLE, counter 0, FrameStrobe 0, FrameData 0, done 0, err 0, busy 0.
REQ-031 Reset asserted mid-SETUP/STROBE/HOLD SHALL abort the write with no done pulse; after release the first cycle is IDLE with req_ready = 1.
REQ-032 While Reset = 1, req_ready SHALL be 0 and no request SHALL be accepted.

Verification
REQ-033 Defaults, accept frame 3, data 0xDEADBEEF -> FrameData = 0xDEADBEEF from next cycle, FrameStrobe = 0x00008 in cycle 3 after accept only, done in cycle 5, busy cycles 1-4.
REQ-034 Accept frame 19 then frame 0 presented in done cycle -> strobes 0x80000 then 0x00001, second done 5 cycles after second accept, no idle gap.
REQ-035 Accept frame 20 -> err pulse 1 cycle, FrameStrobe stays 0, FrameData unchanged, req_ready stays 1, no done.
REQ-036 Assert Reset during STROBE of frame 7 -> FrameStrobe 0 and FrameData 0 without clock edge, no done; after release, request frame 1 completes normally.
REQ-037 SetupCycles=1, StrobeCycles=3, HoldCycles=2 -> strobe high cycles 2-4 after accept, done at cycle 7.
REQ-038 Toggle req_valid/req_data while busy -> no effect on FrameData/FrameStrobe; assertion checks one-hot-or-zero FrameStrobe every cycle.
